// File: rtl/traffic_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : traffic_pkg                                                 |
// | Purpose  : Shared road encodings, widths and green-time clamp defaults |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
package traffic_pkg;

    localparam int TIME_W = 8;

    localparam logic [1:0] ROAD_N = 2'd0;
    localparam logic [1:0] ROAD_E = 2'd1;
    localparam logic [1:0] ROAD_S = 2'd2;
    localparam logic [1:0] ROAD_W = 2'd3;

    localparam int TG_MIN_DEF = 5;
    localparam int TG_MAX_DEF = 120;

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/adapt_calc.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : adapt_calc                                                  |
// | Purpose  : Combinational green-time adaptation for one approach, with  |
// |            clamp and empty-road rule (ADAPT_ZERO_SKIP_EN selects 0).    |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module adapt_calc
    import traffic_pkg::*;
#(
    parameter int TG_MIN = TG_MIN_DEF,
    parameter int TG_MAX = TG_MAX_DEF
) (
    input  logic [TIME_W-1:0] n_r,
    input  logic [TIME_W-1:0] avg,
    input  logic [TIME_W-1:0] tgi,
    output logic [TIME_W-1:0] tg
);

    localparam logic signed [10:0] c_min = 11'(TG_MIN);
    localparam logic signed [10:0] c_max = 11'(TG_MAX);

`ifdef ADAPT_ZERO_SKIP_EN
    localparam logic [TIME_W-1:0] c_empty_tg = '0;
`else
    localparam logic [TIME_W-1:0] c_empty_tg = TIME_W'(TG_MIN);
`endif

    logic        [TIME_W-1:0] w_diff;
    logic signed [10:0]       w_base;
    logic signed [10:0]       w_delta;
    logic signed [10:0]       w_raw;

    // Half of the distance from the average, added or removed from the base.
    always_comb begin
        w_diff  = '0;
        w_delta = '0;
        if (n_r > avg) begin
            w_diff  = n_r - avg;
            w_delta = $signed({3'b000, (w_diff >> 1)});
        end else if (n_r < avg) begin
            w_diff  = avg - n_r;
            w_delta = -$signed({3'b000, (w_diff >> 1)});
        end
    end

    assign w_base = $signed({3'b000, tgi});
    assign w_raw  = w_base + w_delta;

    always_comb begin
        tg = w_raw[TIME_W-1:0];
        if (n_r == '0) begin
            tg = c_empty_tg;
        end else if (w_raw < c_min) begin
            tg = c_min[TIME_W-1:0];
        end else if (w_raw > c_max) begin
            tg = c_max[TIME_W-1:0];
        end
    end

endmodule : adapt_calc
`default_nettype wire

// File: rtl/adaptation.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : adaptation                                                  |
// | Purpose  : Per-approach registered green times; adapts the approach    |
// |            selected by next_road each clock (see ADAPT_ZERO_SKIP_EN).  |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module adaptation
    import traffic_pkg::*;
#(
    parameter int TG_MIN = TG_MIN_DEF,
    parameter int TG_MAX = TG_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        next_road,
    input  logic [TIME_W-1:0] N_n,
    input  logic [TIME_W-1:0] N_e,
    input  logic [TIME_W-1:0] N_s,
    input  logic [TIME_W-1:0] N_w,
    input  logic [TIME_W-1:0] TGin,
    input  logic [TIME_W-1:0] TGie,
    input  logic [TIME_W-1:0] TGis,
    input  logic [TIME_W-1:0] TGiw,
    output logic [TIME_W-1:0] TGn,
    output logic [TIME_W-1:0] TGe,
    output logic [TIME_W-1:0] TGs,
    output logic [TIME_W-1:0] TGw
);

    logic [9:0]        w_sum;
    logic [TIME_W-1:0] w_avg;
    logic [TIME_W-1:0] w_sel_n;
    logic [TIME_W-1:0] w_sel_tgi;
    logic [TIME_W-1:0] w_new_tg;

    logic [TIME_W-1:0] r_tgn;
    logic [TIME_W-1:0] r_tge;
    logic [TIME_W-1:0] r_tgs;
    logic [TIME_W-1:0] r_tgw;

    // Four 8-bit counts fit in 10 bits, so the average never overflows.
    assign w_sum = {2'b00, N_n} + {2'b00, N_e} + {2'b00, N_s} + {2'b00, N_w};
    assign w_avg = TIME_W'(w_sum >> 2);

    always_comb begin
        w_sel_n   = N_n;
        w_sel_tgi = TGin;
        case (next_road)
            ROAD_N: begin w_sel_n = N_n; w_sel_tgi = TGin; end
            ROAD_E: begin w_sel_n = N_e; w_sel_tgi = TGie; end
            ROAD_S: begin w_sel_n = N_s; w_sel_tgi = TGis; end
            ROAD_W: begin w_sel_n = N_w; w_sel_tgi = TGiw; end
            default: begin w_sel_n = N_n; w_sel_tgi = TGin; end
        endcase
    end

    adapt_calc #(
        .TG_MIN (TG_MIN),
        .TG_MAX (TG_MAX)
    ) u_adapt_calc (
        .n_r (w_sel_n),
        .avg (w_avg),
        .tgi (w_sel_tgi),
        .tg  (w_new_tg)
    );

    // Reset loads raw bases unclamped; adaptation always goes through the clamp.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tgn <= TGin;
            r_tge <= TGie;
            r_tgs <= TGis;
            r_tgw <= TGiw;
        end else begin
            case (next_road)
                ROAD_N:  r_tgn <= w_new_tg;
                ROAD_E:  r_tge <= w_new_tg;
                ROAD_S:  r_tgs <= w_new_tg;
                ROAD_W:  r_tgw <= w_new_tg;
                default: r_tgn <= w_new_tg;
            endcase
        end
    end

    assign TGn = r_tgn;
    assign TGe = r_tge;
    assign TGs = r_tgs;
    assign TGw = r_tgw;

endmodule : adaptation
`default_nettype wire

// File: tb/tb_adaptation.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_adaptation                                               |
// | Purpose  : Directed self-checking bench for adaptation                 |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_adaptation;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] next_road;
    logic [7:0] N_n, N_e, N_s, N_w;
    logic [7:0] TGin, TGie, TGis, TGiw;
    logic [7:0] TGn, TGe, TGs, TGw;

    int checks   = 0;
    int failures = 0;

`ifdef ADAPT_ZERO_SKIP_EN
    localparam int c_empty_exp = 0;
`else
    localparam int c_empty_exp = 5;
`endif

    adaptation dut (
        .clk       (clk),
        .reset     (reset),
        .next_road (next_road),
        .N_n       (N_n),
        .N_e       (N_e),
        .N_s       (N_s),
        .N_w       (N_w),
        .TGin      (TGin),
        .TGie      (TGie),
        .TGis      (TGis),
        .TGiw      (TGiw),
        .TGn       (TGn),
        .TGe       (TGe),
        .TGs       (TGs),
        .TGw       (TGw)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_counts(input int n, input int e, input int s, input int w);
        N_n = 8'(n); N_e = 8'(e); N_s = 8'(s); N_w = 8'(w);
    endtask

    task automatic check_all(input string tag, input int n, input int e, input int s, input int w);
        check({tag, "_n"}, int'(TGn), n);
        check({tag, "_e"}, int'(TGe), e);
        check({tag, "_s"}, int'(TGs), s);
        check({tag, "_w"}, int'(TGw), w);
    endtask

    initial begin
        reset = 1'b1; next_road = 2'd0;
        TGin = 8'd10; TGie = 8'd10; TGis = 8'd10; TGiw = 8'd10;
        set_counts(77, 3, 250, 9);
        tick();
        check_all("reset", 10, 10, 10, 10);

        // Increase on N, decrease on E (avg 25)
        reset = 1'b0;
        set_counts(43, 22, 20, 15);
        next_road = 2'd0; tick();
        check_all("inc_n", 19, 10, 10, 10);
        next_road = 2'd1; tick();
        check_all("dec_e", 19, 9, 10, 10);
        tick();
        check("hold_e", int'(TGe), 9);

        // Reset mid-operation, then resume
        reset = 1'b1; tick();
        check_all("mid_reset", 10, 10, 10, 10);
        reset = 1'b0; next_road = 2'd0; tick();
        check_all("resume", 19, 10, 10, 10);

        // Empty road and decrease (avg 13)
        set_counts(3, 34, 0, 15);
        next_road = 2'd2; tick();
        check("empty_s", int'(TGs), c_empty_exp);
        next_road = 2'd3; tick();
        check("inc_w", int'(TGw), 11);
        next_road = 2'd1; tick();
        check("inc_e", int'(TGe), 20);
        check("hold_n", int'(TGn), 19);

        // Ceiling clamp
        TGin = 8'd100; set_counts(200, 0, 0, 0);
        next_road = 2'd0; tick();
        check("ceil_n", int'(TGn), 120);

        // Floor clamp (avg 150)
        TGin = 8'd10; set_counts(1, 200, 200, 200);
        tick();
        check("floor_n", int'(TGn), 5);

        // Count equals average: raw is the base
        set_counts(8, 8, 8, 8);
        tick();
        check("equal_n", int'(TGn), 10);

        // Out-of-range base: unclamped on reset, clamped on adaptation
        TGin = 8'd200; reset = 1'b1; tick();
        check("rst_unclamped_n", int'(TGn), 200);
        reset = 1'b0; tick();
        check("base_hi_clamp_n", int'(TGn), 120);
        TGin = 8'd2; tick();
        check("base_lo_clamp_n", int'(TGn), 5);

        // Maximum counts: sum 1020, no overflow
        set_counts(255, 255, 255, 255);
        TGie = 8'd30; next_road = 2'd1; tick();
        check("max_cnt_e", int'(TGe), 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule : tb_adaptation
`default_nettype wire
